// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the CPU core.
// Fetches from instruction memory (req/ack), presents each instruction
// downstream (valid/ready), then advances the PC by +1 or loads a jump target.
// Optional build macro PC_SEQ_TIMEOUT_EN adds a fetch-ack timeout that raises
// a sticky fault and parks the sequencer in HALTED.
module pc_sequencer #(
   parameter int unsigned         WIDTH        = 8,
   parameter logic [WIDTH-1:0]    RESET_VECTOR = '0
`ifdef PC_SEQ_TIMEOUT_EN
   , parameter int unsigned       TIMEOUT      = 15
`endif
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             run_i,
   input  logic             halt_i,
   input  logic             resume_i,
   output logic             mem_req_o,
   output logic [WIDTH-1:0] mem_addr_o,
   input  logic             mem_ack_i,
   input  logic [WIDTH-1:0] mem_data_i,
   output logic             instr_valid_o,
   output logic [WIDTH-1:0] instr_o,
   output logic [WIDTH-1:0] instr_pc_o,
   input  logic             instr_ready_i,
   input  logic             jump_i,
   input  logic [WIDTH-1:0] jump_target_i,
   output logic [WIDTH-1:0] pc_o,
   output logic             halted_o,
   output logic             fault_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_ISSUE  = 2'd2,
      S_HALTED = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic             mem_req_q;
   logic             instr_valid_q;
   logic             halted_q;
   logic             accept_c;
   logic             timeout_c;

   assign accept_c = instr_valid_q & instr_ready_i;

`ifdef PC_SEQ_TIMEOUT_EN
   logic [WIDTH-1:0] tmo_cnt_q;
   logic             fault_q;

   // Last unacknowledged FETCH cycle before the limit is reached.
   assign timeout_c = (state_q == S_FETCH) && !mem_ack_i &&
                      (tmo_cnt_q == WIDTH'(TIMEOUT - 1));

   // Count FETCH cycles without ack; zero outside FETCH so each entry starts clean.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         tmo_cnt_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         if (state_q != S_FETCH) begin
            tmo_cnt_q <= '0;
         end else if (!mem_ack_i) begin
            tmo_cnt_q <= tmo_cnt_q + WIDTH'(1);
         end
         if (timeout_c) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign fault_o = fault_q;
`else
   assign timeout_c = 1'b0;
   assign fault_o   = 1'b0;
`endif

   // Next-state, PC update and instruction capture.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      unique case (state_q)
         S_IDLE: begin
            if (run_i) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem_ack_i) begin
               instr_d    = mem_data_i;
               instr_pc_d = pc_q;
               state_d    = S_ISSUE;
            end else if (timeout_c) begin
               state_d = S_HALTED;
            end
         end
         S_ISSUE: begin
            if (accept_c) begin
               pc_d = jump_i ? jump_target_i : pc_q + WIDTH'(1);
               if (halt_i) begin
                  state_d = S_HALTED;
               end else if (run_i) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HALTED: begin
            // halt wins over resume on the same cycle
            if (resume_i && !halt_i) begin
               state_d = run_i ? S_FETCH : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_VECTOR;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         mem_req_q     <= (state_d == S_FETCH);
         instr_valid_q <= (state_d == S_ISSUE);
         halted_q      <= (state_d == S_HALTED);
      end
   end

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = pc_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign pc_o          = pc_q;
   assign halted_o      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run checked against a transaction-level model of the sequencing rules.
module tb_pc_sequencer;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       run_i, halt_i, resume_i;
   logic       mem_req_o, mem_ack_i;
   logic [7:0] mem_addr_o, mem_data_i;
   logic       instr_valid_o, instr_ready_i;
   logic [7:0] instr_o, instr_pc_o;
   logic       jump_i;
   logic [7:0] jump_target_i;
   logic [7:0] pc_o;
   logic       halted_o, fault_o;

   int n_cmp  = 0;
   int n_fail = 0;

   pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h00)) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .run_i         (run_i),
      .halt_i        (halt_i),
      .resume_i      (resume_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_data_i    (mem_data_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .jump_i        (jump_i),
      .jump_target_i (jump_target_i),
      .pc_o          (pc_o),
      .halted_o      (halted_o),
      .fault_o       (fault_o)
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_reset();
      run_i = 0; halt_i = 0; resume_i = 0; mem_ack_i = 0; mem_data_i = 0;
      instr_ready_i = 0; jump_i = 0; jump_target_i = 0;
      reset_i = 1;
      step();
      step();
      reset_i = 0;
   endtask

   task automatic test_reset();
      logic [27:0] got;
      do_reset();
      got = {mem_req_o, instr_valid_o, halted_o, fault_o, pc_o, instr_o, instr_pc_o};
      n_cmp++;
      if (got !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", got, 28'h0);
      end
      step();
      n_cmp++;
      if ({mem_req_o, instr_valid_o, mem_addr_o} !== 10'h0) begin
         n_fail++;
         $display("FAIL idle_quiet: req=%b valid=%b addr=%h want 0 0 00", mem_req_o, instr_valid_o, mem_addr_o);
      end
   endtask

   task automatic test_stream();
      logic [7:0] k;
      do_reset();
      run_i = 1; mem_ack_i = 1; instr_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         k = 8'(i);
         step();
         n_cmp++;
         if ({mem_req_o, instr_valid_o, mem_addr_o} !== {1'b1, 1'b0, k}) begin
            n_fail++;
            $display("FAIL stream_fetch%0d: req=%b valid=%b addr=%h want 1 0 %h", i, mem_req_o, instr_valid_o, mem_addr_o, k);
         end
         mem_data_i = mem_addr_o + 8'h10;
         step();
         n_cmp++;
         if ({instr_valid_o, mem_req_o, instr_o, instr_pc_o} !== {1'b1, 1'b0, k + 8'h10, k}) begin
            n_fail++;
            $display("FAIL stream_issue%0d: valid=%b req=%b instr=%h ipc=%h want 1 0 %h %h", i, instr_valid_o, mem_req_o, instr_o, instr_pc_o, k + 8'h10, k);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      mem_data_i = 8'h42;
      run_i = 1; mem_ack_i = 1; instr_ready_i = 0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({instr_valid_o, instr_o, pc_o} !== {1'b1, 8'h42, 8'h00}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h want 1 42 00", i, instr_valid_o, instr_o, pc_o);
         end
         if (i < 4) step();
      end
      instr_ready_i = 1;
      step();
      instr_ready_i = 0; mem_ack_i = 0;
      n_cmp++;
      if ({pc_o, instr_valid_o, mem_req_o} !== {8'h01, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_release: pc=%h valid=%b req=%b want 01 0 1", pc_o, instr_valid_o, mem_req_o);
      end
   endtask

   task automatic test_jump_wrap();
      do_reset();
      mem_data_i = 8'hA5;
      run_i = 1; mem_ack_i = 1; instr_ready_i = 0;
      step();
      step();
      jump_i = 1; jump_target_i = 8'h33;
      step();
      n_cmp++;
      if ({pc_o, instr_valid_o} !== {8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL jump_nonaccept: pc=%h valid=%b want 00 1", pc_o, instr_valid_o);
      end
      jump_target_i = 8'hF0; instr_ready_i = 1;
      step();
      jump_i = 0; instr_ready_i = 0;
      n_cmp++;
      if ({pc_o, mem_addr_o, mem_req_o} !== {8'hF0, 8'hF0, 1'b1}) begin
         n_fail++;
         $display("FAIL jump_taken: pc=%h addr=%h req=%b want f0 f0 1", pc_o, mem_addr_o, mem_req_o);
      end
      step();
      jump_i = 1; jump_target_i = 8'h77;
      step();
      jump_i = 0; instr_ready_i = 1;
      step();
      instr_ready_i = 0;
      n_cmp++;
      if ({pc_o, mem_addr_o} !== {8'hF1, 8'hF1}) begin
         n_fail++;
         $display("FAIL jump_ignored: pc=%h addr=%h want f1 f1", pc_o, mem_addr_o);
      end
      step();
      jump_i = 1; jump_target_i = 8'hF1; instr_ready_i = 1;
      step();
      jump_i = 0; instr_ready_i = 0;
      n_cmp++;
      if ({pc_o, mem_addr_o, mem_req_o} !== {8'hF1, 8'hF1, 1'b1}) begin
         n_fail++;
         $display("FAIL jump_self: pc=%h addr=%h req=%b want f1 f1 1", pc_o, mem_addr_o, mem_req_o);
      end
      step();
      jump_i = 1; jump_target_i = 8'hFF; instr_ready_i = 1;
      step();
      jump_i = 0; instr_ready_i = 0;
      step();
      n_cmp++;
      if ({instr_valid_o, instr_pc_o} !== {1'b1, 8'hFF}) begin
         n_fail++;
         $display("FAIL wrap_issue: valid=%b ipc=%h want 1 ff", instr_valid_o, instr_pc_o);
      end
      instr_ready_i = 1;
      step();
      instr_ready_i = 0;
      n_cmp++;
      if ({pc_o, mem_addr_o} !== {8'h00, 8'h00}) begin
         n_fail++;
         $display("FAIL wrap_pc: pc=%h addr=%h want 00 00", pc_o, mem_addr_o);
      end
   endtask

   task automatic test_halt();
      do_reset();
      mem_data_i = 8'h3C;
      run_i = 1; mem_ack_i = 1; instr_ready_i = 0;
      step();
      step();
      jump_i = 1; jump_target_i = 8'h05; instr_ready_i = 1;
      step();
      jump_i = 0; instr_ready_i = 0;
      step();
      halt_i = 1; instr_ready_i = 1;
      step();
      instr_ready_i = 0;
      n_cmp++;
      if ({halted_o, pc_o, mem_req_o, instr_valid_o} !== {1'b1, 8'h06, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL halt_enter: halted=%b pc=%h req=%b valid=%b want 1 06 0 0", halted_o, pc_o, mem_req_o, instr_valid_o);
      end
      step();
      resume_i = 1;
      step();
      n_cmp++;
      if ({halted_o, mem_req_o, pc_o} !== {1'b1, 1'b0, 8'h06}) begin
         n_fail++;
         $display("FAIL halt_priority: halted=%b req=%b pc=%h want 1 0 06", halted_o, mem_req_o, pc_o);
      end
      halt_i = 0;
      step();
      resume_i = 0;
      n_cmp++;
      if ({halted_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 8'h06}) begin
         n_fail++;
         $display("FAIL resume_fetch: halted=%b req=%b addr=%h want 0 1 06", halted_o, mem_req_o, mem_addr_o);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      mem_data_i = 8'h99;
      run_i = 1; mem_ack_i = 1; instr_ready_i = 0;
      step();
      step();
      jump_i = 1; jump_target_i = 8'h20; instr_ready_i = 1;
      step();
      jump_i = 0; instr_ready_i = 0; mem_ack_i = 0;
      step();
      step();
      n_cmp++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 8'h20}) begin
         n_fail++;
         $display("FAIL areset_pre: req=%b addr=%h want 1 20", mem_req_o, mem_addr_o);
      end
      #3;
      reset_i = 1; run_i = 0;
      #1;
      n_cmp++;
      if ({mem_req_o, pc_o, instr_valid_o, halted_o} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL areset_immediate: req=%b pc=%h valid=%b halted=%b want 0 00 0 0", mem_req_o, pc_o, instr_valid_o, halted_o);
      end
      mem_ack_i = 1;
      step();
      #2;
      reset_i = 0;
      step();
      step();
      n_cmp++;
      if ({mem_req_o, instr_valid_o, instr_o, pc_o} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
         n_fail++;
         $display("FAIL areset_late_ack: req=%b valid=%b instr=%h pc=%h want 0 0 00 00", mem_req_o, instr_valid_o, instr_o, pc_o);
      end
      mem_ack_i = 0;
   endtask

   task automatic test_timeout();
      do_reset();
      mem_data_i = 8'h5A;
      run_i = 1; mem_ack_i = 0; instr_ready_i = 0;
`ifdef PC_SEQ_TIMEOUT_EN
      for (int i = 0; i < 15; i++) step();
      n_cmp++;
      if ({mem_req_o, fault_o, halted_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL timeout_before: req=%b fault=%b halted=%b want 1 0 0", mem_req_o, fault_o, halted_o);
      end
      step();
      n_cmp++;
      if ({mem_req_o, fault_o, halted_o, pc_o} !== {3'b011, 8'h00}) begin
         n_fail++;
         $display("FAIL timeout_hit: req=%b fault=%b halted=%b pc=%h want 0 1 1 00", mem_req_o, fault_o, halted_o, pc_o);
      end
      mem_ack_i = 1; resume_i = 1;
      step();
      resume_i = 0;
      step();
      n_cmp++;
      if ({instr_valid_o, instr_o, fault_o, halted_o} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL timeout_retry: valid=%b instr=%h fault=%b halted=%b want 1 5a 1 0", instr_valid_o, instr_o, fault_o, halted_o);
      end
`else
      for (int i = 0; i < 20; i++) step();
      n_cmp++;
      if ({mem_req_o, fault_o, halted_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL no_timeout_wait: req=%b fault=%b halted=%b want 1 0 0", mem_req_o, fault_o, halted_o);
      end
`endif
   endtask

   // Transaction-level model: phase 0 idle, 1 fetching, 2 presenting, 3 halted.
   task automatic test_random();
      int         ph;
      int         miss;
      logic [7:0] m_pc, m_instr, m_ipc;
      logic [7:0] nxt_pc;
      do_reset();
      ph = 0; miss = 0; m_pc = 8'h00; m_instr = 8'h00; m_ipc = 8'h00;
      for (int c = 0; c < 500; c++) begin
         run_i         = ($urandom_range(0, 9) != 0);
         halt_i        = ($urandom_range(0, 9) < 2);
         resume_i      = ($urandom_range(0, 9) < 3);
         instr_ready_i = ($urandom_range(0, 9) < 6);
         jump_i        = ($urandom_range(0, 9) < 3);
         jump_target_i = 8'($urandom);
         mem_data_i    = 8'($urandom);
         mem_ack_i     = ($urandom_range(0, 1) == 1) || (miss >= 5);
         nxt_pc = jump_i ? jump_target_i : m_pc + 8'd1;
         case (ph)
            0: if (run_i) ph = 1;
            1: begin
               if (mem_ack_i) begin
                  m_instr = mem_data_i; m_ipc = m_pc; ph = 2; miss = 0;
               end else begin
                  miss++;
               end
            end
            2: if (instr_ready_i) begin
               m_pc = nxt_pc;
               ph = halt_i ? 3 : (run_i ? 1 : 0);
            end
            default: if (resume_i && !halt_i) ph = run_i ? 1 : 0;
         endcase
         step();
         n_cmp++;
         if ({mem_req_o, instr_valid_o, halted_o, pc_o, mem_addr_o} !==
             {ph == 1, ph == 2, ph == 3, m_pc, m_pc}) begin
            n_fail++;
            $display("FAIL rand_ctl@%0d: req=%b valid=%b halted=%b pc=%h addr=%h want phase %0d pc %h", c, mem_req_o, instr_valid_o, halted_o, pc_o, mem_addr_o, ph, m_pc);
         end
         if (ph == 2) begin
            n_cmp++;
            if ({instr_o, instr_pc_o} !== {m_instr, m_ipc}) begin
               n_fail++;
               $display("FAIL rand_instr@%0d: instr=%h ipc=%h want %h %h", c, instr_o, instr_pc_o, m_instr, m_ipc);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_jump_wrap();
      test_halt();
      test_async_reset();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
